// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: data-side priority with a fetch starvation guard and a registered
// request/ack/valid handshake. Optional region checking is enabled by defining MEM_ARB_ERR_EN.
module mem_arbiter #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] ROM_LIMIT    = WIDTH'(32'h1000_0000),
    parameter int               STARVE_LIMIT = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             if_req_i,
    input  logic [WIDTH-1:0] if_addr_i,
    output logic             if_ack_o,
    output logic             if_valid_o,
    output logic [WIDTH-1:0] if_rdata_o,
    input  logic             dm_req_i,
    input  logic             dm_we_i,
    input  logic [WIDTH-1:0] dm_addr_i,
    input  logic [WIDTH-1:0] dm_wdata_i,
    output logic             dm_ack_o,
    output logic             dm_valid_o,
    output logic [WIDTH-1:0] dm_rdata_o,
    output logic             mem_we_o,
    output logic [WIDTH-1:0] mem_addr_o,
    output logic [WIDTH-1:0] mem_wdata_o,
    input  logic [WIDTH-1:0] mem_rdata_i,
    output logic             err_o,
    output logic [WIDTH-1:0] err_addr_o
);

    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

`ifdef MEM_ARB_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACC_IF = 2'd1,
        ST_ACC_DM = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_starve_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic [WIDTH-1:0] r_addr;
    logic [WIDTH-1:0] r_wdata;
    logic             r_we;
    logic             r_mem_we;
    logic             r_if_ack;
    logic             r_dm_ack;
    logic             r_if_valid;
    logic             r_dm_valid;
    logic [WIDTH-1:0] r_if_rdata;
    logic [WIDTH-1:0] r_dm_rdata;
    logic             r_err;
    logic [WIDTH-1:0] r_err_addr;

    logic             w_starved;
    logic             w_dm_win;
    logic             w_if_win;
    logic             w_if_viol;
    logic             w_wr_viol;
    logic [WIDTH-1:0] w_addr_nxt;
    logic [WIDTH-1:0] w_wdata_nxt;
    logic             w_we_nxt;
    logic             w_mem_we_nxt;
    logic             w_if_valid_nxt;
    logic             w_dm_valid_nxt;
    logic [WIDTH-1:0] w_if_rdata_nxt;
    logic [WIDTH-1:0] w_dm_rdata_nxt;
    logic             w_err_nxt;
    logic [WIDTH-1:0] w_err_addr_nxt;

    assign w_starved = (r_starve_cnt == CNT_MAX);
    assign w_dm_win  = dm_req_i & ~w_starved;
    assign w_if_win  = if_req_i & ~w_dm_win;

    // Region checks evaluated against the winning request at grant time.
    assign w_if_viol = ERR_EN & w_if_win & (if_addr_i >= ROM_LIMIT);
    assign w_wr_viol = ERR_EN & w_dm_win & dm_we_i & (dm_addr_i < ROM_LIMIT);

    // Next-state, starvation counter and grant latches.
    always_comb begin
        w_state_nxt  = ST_IDLE;
        w_cnt_nxt    = r_starve_cnt;
        w_addr_nxt   = r_addr;
        w_wdata_nxt  = r_wdata;
        w_we_nxt     = 1'b0;
        w_mem_we_nxt = 1'b0;
        if (w_dm_win) begin
            w_state_nxt  = ST_ACC_DM;
            w_addr_nxt   = dm_addr_i;
            w_wdata_nxt  = dm_wdata_i;
            w_we_nxt     = dm_we_i;
            w_mem_we_nxt = dm_we_i & ~w_wr_viol;
            if (if_req_i && (r_starve_cnt != CNT_MAX)) begin
                w_cnt_nxt = r_starve_cnt + CNT_W'(1);
            end else if (if_req_i) begin
                w_cnt_nxt = r_starve_cnt;
            end else begin
                w_cnt_nxt = {CNT_W{1'b0}};
            end
        end else if (w_if_win) begin
            w_state_nxt = ST_ACC_IF;
            w_addr_nxt  = if_addr_i;
            w_cnt_nxt   = {CNT_W{1'b0}};
        end else begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = {CNT_W{1'b0}};
        end
    end

    // Completion of the access that is closing at this edge.
    always_comb begin
        w_if_valid_nxt = 1'b0;
        w_dm_valid_nxt = 1'b0;
        w_if_rdata_nxt = r_if_rdata;
        w_dm_rdata_nxt = r_dm_rdata;
        case (r_state)
            ST_ACC_IF: begin
                w_if_valid_nxt = 1'b1;
                w_if_rdata_nxt = mem_rdata_i;
            end
            ST_ACC_DM: begin
                w_dm_valid_nxt = 1'b1;
                if (!r_we) begin
                    w_dm_rdata_nxt = mem_rdata_i;
                end else begin
                    w_dm_rdata_nxt = r_dm_rdata;
                end
            end
            default: begin
                w_if_valid_nxt = 1'b0;
                w_dm_valid_nxt = 1'b0;
            end
        endcase
    end

    // Sticky error flag; only the first offending address is kept.
    always_comb begin
        w_err_nxt      = r_err | w_if_viol | w_wr_viol;
        w_err_addr_nxt = r_err_addr;
        if (!r_err && w_if_viol) begin
            w_err_addr_nxt = if_addr_i;
        end else if (!r_err && w_wr_viol) begin
            w_err_addr_nxt = dm_addr_i;
        end else begin
            w_err_addr_nxt = r_err_addr;
        end
    end

    // FSM state and starvation counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_starve_cnt <= {CNT_W{1'b0}};
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_cnt_nxt;
        end
    end

    // Registered datapath and handshake outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_addr     <= {WIDTH{1'b0}};
            r_wdata    <= {WIDTH{1'b0}};
            r_we       <= 1'b0;
            r_mem_we   <= 1'b0;
            r_if_ack   <= 1'b0;
            r_dm_ack   <= 1'b0;
            r_if_valid <= 1'b0;
            r_dm_valid <= 1'b0;
            r_if_rdata <= {WIDTH{1'b0}};
            r_dm_rdata <= {WIDTH{1'b0}};
            r_err      <= 1'b0;
            r_err_addr <= {WIDTH{1'b0}};
        end else begin
            r_addr     <= w_addr_nxt;
            r_wdata    <= w_wdata_nxt;
            r_we       <= w_we_nxt;
            r_mem_we   <= w_mem_we_nxt;
            r_if_ack   <= w_if_win;
            r_dm_ack   <= w_dm_win;
            r_if_valid <= w_if_valid_nxt;
            r_dm_valid <= w_dm_valid_nxt;
            r_if_rdata <= w_if_rdata_nxt;
            r_dm_rdata <= w_dm_rdata_nxt;
            r_err      <= w_err_nxt;
            r_err_addr <= w_err_addr_nxt;
        end
    end

    assign if_ack_o    = r_if_ack;
    assign if_valid_o  = r_if_valid;
    assign if_rdata_o  = r_if_rdata;
    assign dm_ack_o    = r_dm_ack;
    assign dm_valid_o  = r_dm_valid;
    assign dm_rdata_o  = r_dm_rdata;
    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;
    assign err_o       = r_err;
    assign err_addr_o  = r_err_addr;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed stimulus pushes expected completions,
// a negedge monitor pops and compares them when valid pulses appear.
module tb_mem_arbiter;

    localparam logic [31:0] ROM_LIM = 32'h1000_0000;
`ifdef MEM_ARB_ERR_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = 32'h0;
    logic        if_ack_o, if_valid_o;
    logic [31:0] if_rdata_o;
    logic        dm_req_i = 1'b0;
    logic        dm_we_i = 1'b0;
    logic [31:0] dm_addr_i = 32'h0;
    logic [31:0] dm_wdata_i = 32'h0;
    logic        dm_ack_o, dm_valid_o;
    logic [31:0] dm_rdata_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic        err_o;
    logic [31:0] err_addr_o;

    mem_arbiter dut (
        .clock(clock), .reset_n(reset_n),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ack_o(if_ack_o),
        .if_valid_o(if_valid_o), .if_rdata_o(if_rdata_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
        .dm_wdata_i(dm_wdata_i), .dm_ack_o(dm_ack_o), .dm_valid_o(dm_valid_o),
        .dm_rdata_o(dm_rdata_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
        .err_o(err_o), .err_addr_o(err_addr_o)
    );

    always #5 clock = ~clock;

    // Memory system: ROM word is a fixed function of the address, RAM is a small array.
    logic [31:0] ram [0:15] = '{default: 32'h0};
    always_comb begin
        if (mem_addr_o < ROM_LIM) mem_rdata_i = mem_addr_o ^ 32'hA5A5_0000;
        else                      mem_rdata_i = ram[mem_addr_o[5:2]];
    end
    always @(posedge clock) begin
        if (mem_we_o && (mem_addr_o >= ROM_LIM)) ram[mem_addr_o[5:2]] <= mem_wdata_o;
    end

    typedef struct packed {
        int unsigned due;
        logic [31:0] data;
    } exp_t;

    exp_t        if_q[$];
    exp_t        dm_q[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Monitor: every valid pulse must match the oldest expectation, on its due cycle.
    always @(negedge clock) begin
        exp_t e;
        if (reset_n) begin
            if (if_valid_o) begin
                if (if_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL if_valid_unexpected actual=1 expected=0 cyc=%0d", cyc);
                end else begin
                    e = if_q.pop_front();
                    chk("if_valid_cycle", cyc, e.due);
                    chk("if_rdata", if_rdata_o, e.data);
                end
            end else if (if_q.size() != 0 && if_q[0].due <= cyc) begin
                e = if_q.pop_front();
                checks++; errors++;
                $display("FAIL if_valid_missing actual=0 expected=1 due=%0d", e.due);
            end
            if (dm_valid_o) begin
                if (dm_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL dm_valid_unexpected actual=1 expected=0 cyc=%0d", cyc);
                end else begin
                    e = dm_q.pop_front();
                    chk("dm_valid_cycle", cyc, e.due);
                    chk("dm_rdata", dm_rdata_o, e.data);
                end
            end else if (dm_q.size() != 0 && dm_q[0].due <= cyc) begin
                e = dm_q.pop_front();
                checks++; errors++;
                $display("FAIL dm_valid_missing actual=0 expected=1 due=%0d", e.due);
            end
        end
    end

    initial begin
        logic [5:0] pat;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_if_ack", 32'(if_ack_o), 32'd0);
        chk("rst_dm_ack", 32'(dm_ack_o), 32'd0);
        chk("rst_mem_we", 32'(mem_we_o), 32'd0);
        chk("rst_mem_addr", mem_addr_o, 32'h0);
        chk("rst_err", 32'(err_o), 32'd0);
        reset_n = 1'b1;
        tick();

        // Lone fetch from ROM.
        if_req_i = 1'b1; if_addr_i = 32'h0000_0010;
        tick();
        chk("if_ack", 32'(if_ack_o), 32'd1);
        chk("if_dm_ack", 32'(dm_ack_o), 32'd0);
        chk("if_mem_addr", mem_addr_o, 32'h0000_0010);
        chk("if_mem_we", 32'(mem_we_o), 32'd0);
        if_q.push_back('{due: cyc + 1, data: 32'hA5A5_0010});
        if_req_i = 1'b0;
        tick();
        chk("if_ack_drop", 32'(if_ack_o), 32'd0);
        chk("idle_mem_we", 32'(mem_we_o), 32'd0);
        chk("idle_addr_hold", mem_addr_o, 32'h0000_0010);

        // Write then back-to-back read of the same RAM word.
        dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h1000_0008; dm_wdata_i = 32'hDEAD_BEEF;
        tick();
        chk("wr_ack", 32'(dm_ack_o), 32'd1);
        chk("wr_mem_we", 32'(mem_we_o), 32'd1);
        chk("wr_mem_addr", mem_addr_o, 32'h1000_0008);
        chk("wr_mem_wdata", mem_wdata_o, 32'hDEAD_BEEF);
        dm_q.push_back('{due: cyc + 1, data: 32'h0});
        dm_we_i = 1'b0;
        tick();
        chk("rd_ack", 32'(dm_ack_o), 32'd1);
        chk("rd_mem_we", 32'(mem_we_o), 32'd0);
        dm_q.push_back('{due: cyc + 1, data: 32'hDEAD_BEEF});
        dm_req_i = 1'b0;
        tick();
        chk("rd_ack_drop", 32'(dm_ack_o), 32'd0);
        tick();

        // Both requesting continuously: four DM grants, then IF, then DM.
        if_req_i = 1'b1; if_addr_i = 32'h0000_0020;
        dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h1000_0008;
        pat = 6'b01_0000;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (pat[i]) begin
                chk("starve_if_ack", 32'(if_ack_o), 32'd1);
                chk("starve_if_addr", mem_addr_o, 32'h0000_0020);
                if_q.push_back('{due: cyc + 1, data: 32'hA5A5_0020});
            end else begin
                chk("starve_dm_ack", 32'(dm_ack_o), 32'd1);
                chk("starve_dm_addr", mem_addr_o, 32'h1000_0008);
                dm_q.push_back('{due: cyc + 1, data: 32'hDEAD_BEEF});
            end
        end
        if_req_i = 1'b0; dm_req_i = 1'b0;
        tick();
        tick();

        // Write into ROM region, then a fetch from RAM region.
        dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h0000_0020; dm_wdata_i = 32'hCAFE_F00D;
        tick();
        chk("romwr_ack", 32'(dm_ack_o), 32'd1);
        chk("romwr_mem_we", 32'(mem_we_o), ERR_ON ? 32'd0 : 32'd1);
        dm_q.push_back('{due: cyc + 1, data: 32'hDEAD_BEEF});
        dm_req_i = 1'b0; dm_we_i = 1'b0;
        tick();
        chk("romwr_err", 32'(err_o), 32'(ERR_ON));
        chk("romwr_err_addr", err_addr_o, ERR_ON ? 32'h0000_0020 : 32'h0);
        if_req_i = 1'b1; if_addr_i = 32'h1000_0000;
        tick();
        chk("ramif_ack", 32'(if_ack_o), 32'd1);
        if_q.push_back('{due: cyc + 1, data: 32'h0});
        if_req_i = 1'b0;
        tick();
        chk("ramif_err", 32'(err_o), 32'(ERR_ON));
        chk("ramif_err_addr", err_addr_o, ERR_ON ? 32'h0000_0020 : 32'h0);
        tick();

        // Reset during an in-flight RAM write.
        dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h1000_0004; dm_wdata_i = 32'h1234_5678;
        tick();
        chk("rstwr_mem_we", 32'(mem_we_o), 32'd1);
        reset_n = 1'b0; dm_req_i = 1'b0; dm_we_i = 1'b0;
        #1;
        chk("rstwr_mem_we_cleared", 32'(mem_we_o), 32'd0);
        chk("rstwr_dm_ack", 32'(dm_ack_o), 32'd0);
        chk("rstwr_dm_rdata", dm_rdata_o, 32'h0);
        chk("rstwr_if_rdata", if_rdata_o, 32'h0);
        chk("rstwr_mem_addr", mem_addr_o, 32'h0);
        chk("rstwr_mem_wdata", mem_wdata_o, 32'h0);
        chk("rstwr_err", 32'(err_o), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("rst_hold_mem_we", 32'(mem_we_o), 32'd0);
            chk("rst_hold_dm_valid", 32'(dm_valid_o), 32'd0);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("post_rst_dm_valid", 32'(dm_valid_o), 32'd0);
            chk("post_rst_mem_we", 32'(mem_we_o), 32'd0);
        end

        chk("if_q_drained", 32'(if_q.size()), 32'd0);
        chk("dm_q_drained", 32'(dm_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter placed in front of the unified memory system (program ROM below 0x1000_0000, data RAM at and above it). It shares the single memory port between the instruction-fetch requester and the load/store requester. Arbitration is data-priority with a starvation guard for fetch, and every access uses a registered request/acknowledge/valid handshake. Optional address-region checking flags illegal fetches and ROM writes.

## Interface

Parameters:
- `WIDTH`, 32, address/data width
- `ROM_LIMIT`, 32'h10000000, first RAM address; addresses below are ROM
- `STARVE_LIMIT`, 4, consecutive lost arbitrations after which fetch wins

Ports:
- `clock`  input  1  single clock, rising edge
- `reset_n`  input  1  asynchronous, active-low reset
- `if_req_i`  input  1  fetch request, held until acked
- `if_addr_i`  input  WIDTH  fetch address
- `if_ack_o`  output  1  fetch grant, 1-cycle pulse
- `if_valid_o`  output  1  fetch data valid, 1-cycle pulse
- `if_rdata_o`  output  WIDTH  fetched word, held until next fetch completion
- `dm_req_i`  input  1  data request, held until acked
- `dm_we_i`  input  1  1 = write, 0 = read
- `dm_addr_i`  input  WIDTH  data address
- `dm_wdata_i`  input  WIDTH  write data
- `dm_ack_o`  output  1  data grant, 1-cycle pulse
- `dm_valid_o`  output  1  data completion (read or write), 1-cycle pulse
- `dm_rdata_o`  output  WIDTH  read word, updated on reads only
- `mem_we_o`  output  1  write enable to memory system
- `mem_addr_o`  output  WIDTH  address to memory system
- `mem_wdata_o`  output  WIDTH  write data to memory system
- `mem_rdata_i`  input  WIDTH  combinational read data from memory system
- `err_o`  output  1  sticky region-violation flag
- `err_addr_o`  output  WIDTH  address of first violation

## Operation

- States: IDLE, ACC_IF, ACC_DM. Arbitration occurs at every rising edge in any state.
- Winner at an edge: if `dm_req_i` and not starved -> DM; else if `if_req_i` -> IF; else none (go to IDLE).
- Starved: `starve_cnt == STARVE_LIMIT`. `starve_cnt` increments (saturating) at each edge where `if_req_i`=1 and DM wins; clears when IF wins or `if_req_i`=0. Width `$clog2(STARVE_LIMIT+1)`.
- On grant: latch winner address, `we` (0 for IF), wdata; enter ACC_x; raise `x_ack_o` for exactly the ACC_x cycle.
- ACC_x cycle: `mem_addr_o`/`mem_wdata_o` from latches, `mem_we_o` = latched `we` (DM only, unless suppressed). At the closing edge: reads capture `mem_rdata_i` into `x_rdata_o`; `x_valid_o` pulses for the following cycle.
- Requester must drop or replace its request in the cycle its ack is high; a request still high at the closing edge is a new request.
- IDLE: `mem_we_o`=0, `mem_addr_o`/`mem_wdata_o` hold last latched values.
- Reset (any time): state IDLE, counter 0, all outputs 0; in-flight access is discarded with no valid pulse.

## Timing

- Request sampled at edge E0 -> ack high E0..E1 (memory access cycle) -> valid high E1..E2. Read latency 2 cycles from the sampling edge.
- Throughput: one access per cycle; back-to-back grants with no bubble.
- RAM write commits at E1 (memory system's own clock edge).
- Both requests at the same edge: DM wins unless starved.

## Configuration

- `MEM_ARB_ERR_EN` defined: at grant, an IF address >= `ROM_LIMIT` or a DM write with address < `ROM_LIMIT` sets `err_o` (sticky until reset) and captures `err_addr_o` on the first violation only. An offending write is suppressed (`mem_we_o`=0) but still acked and completed; an offending fetch is still performed.
- Not defined: `err_o` and `err_addr_o` tied 0; no write suppression.

## Test plan

- Reset mid-ACC_DM write at address 0x1000_0004 -> no `dm_valid_o`, all outputs 0, `mem_we_o` never high after `reset_n` falls.
- IF read at 0x0000_0010 alone -> `if_ack_o` 1 cycle after sampling edge, `if_valid_o` with `if_rdata_o` = ROM word one cycle later.
- DM write 0xDEADBEEF to 0x1000_0008, then DM read same address back-to-back -> `mem_we_o`=1 for one cycle, then read valid returns 0xDEADBEEF.
- `dm_req_i` and `if_req_i` both held continuously, DM re-requesting every cycle -> IF granted on the 5th arbitration (after 4 DM grants), then DM again.
- With `MEM_ARB_ERR_EN`: DM write to 0x0000_0020 -> `dm_ack_o`/`dm_valid_o` pulse, `mem_we_o` stays 0, `err_o`=1, `err_addr_o`=0x0000_0020; a later IF fetch at 0x1000_0000 leaves `err_addr_o` unchanged.
- Without `MEM_ARB_ERR_EN`: same write -> `mem_we_o`=1, `err_o` remains 0.
